// File: rtl/alarm_pkg.sv
// Shared types and default timing constants for the alarm trigger block.
package alarm_pkg;

  localparam int unsigned DEF_TICK_DIV   = 50_000_000;
  localparam int unsigned DEF_TONE_DIV   = 25_000;
  localparam int unsigned DEF_RING_SEC   = 60;
  localparam int unsigned DEF_SNOOZE_SEC = 300;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZE  = 2'd2
  } alarm_state_t;

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer for an active-low button plus a registered
// one-cycle press pulse on the synchronized falling edge.
module btn_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn_n_i,
  output logic press_o
);

  logic meta_q, sync_q, prev_q, press_q;

  // Flops reset to 1 so a released button never looks like a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q  <= 1'b1;
      sync_q  <= 1'b1;
      prev_q  <= 1'b1;
      press_q <= 1'b0;
    end else begin
      meta_q  <= btn_n_i;
      sync_q  <= meta_q;
      prev_q  <= sync_q;
      press_q <= prev_q & ~sync_q;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/alarm_trigger.sv
// Alarm clock trigger: time match edge detect, ring/snooze FSM with
// second-based timeouts, and a square-wave buzzer driven while ringing.
module alarm_trigger
  import alarm_pkg::*;
#(
  parameter int unsigned TICK_DIV   = DEF_TICK_DIV,
  parameter int unsigned TONE_DIV   = DEF_TONE_DIV,
  parameter int unsigned RING_SEC   = DEF_RING_SEC,   // 1..65535
  parameter int unsigned SNOOZE_SEC = DEF_SNOOZE_SEC  // 1..65535
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       alarm_en,
  input  logic [7:0] time_hour,
  input  logic [7:0] time_minute,
  input  logic [7:0] time_second,
  input  logic [7:0] alarm_hour,
  input  logic [7:0] alarm_minute,
  input  logic [7:0] alarm_second,
  input  logic       stop_n,
  input  logic       snooze_n,
  output logic       buzzer,
  output logic       ringing,
  output logic       snoozed
);

  localparam int TW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TNW = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;

  alarm_state_t   state_q, state_d;
  logic [TW-1:0]  tick_q;
  logic [15:0]    sec_q;
  logic [TNW-1:0] tone_q;
  logic           buzzer_q, ringing_q, snoozed_q;
  logic           match_q, match_prev_q, primed_q;

  logic match, trigger, stop_p, snooze_p;
  logic tick_wrap, ring_done, snz_done, tone_wrap;

  btn_sync_edge u_stop (
    .clk     (clk),
    .rst     (rst),
    .btn_n_i (stop_n),
    .press_o (stop_p)
  );

  btn_sync_edge u_snooze (
    .clk     (clk),
    .rst     (rst),
    .btn_n_i (snooze_n),
    .press_o (snooze_p)
  );

  always_comb begin
    match = alarm_en && (time_hour == alarm_hour) &&
            (time_minute == alarm_minute) && (time_second == alarm_second);
    // primed_q blocks a trigger from a match that was already true at reset release.
    trigger   = match_q & ~match_prev_q & primed_q;
    tick_wrap = (tick_q == TW'(TICK_DIV - 1));
    ring_done = tick_wrap && (sec_q == 16'(RING_SEC - 1));
    snz_done  = tick_wrap && (sec_q == 16'(SNOOZE_SEC - 1));
    tone_wrap = (tone_q == TNW'(TONE_DIV - 1));

    state_d = state_q;
    if (!alarm_en) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (trigger) state_d = RINGING;
        RINGING: begin
          if (stop_p)         state_d = IDLE;
          else if (snooze_p)  state_d = SNOOZE;
          else if (ring_done) state_d = IDLE;
        end
        SNOOZE: begin
          if (stop_p)        state_d = IDLE;
          else if (snz_done) state_d = RINGING;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      tick_q       <= '0;
      sec_q        <= '0;
      tone_q       <= '0;
      buzzer_q     <= 1'b0;
      ringing_q    <= 1'b0;
      snoozed_q    <= 1'b0;
      match_q      <= 1'b0;
      match_prev_q <= 1'b0;
      primed_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      match_q      <= match;
      match_prev_q <= match_q;
      primed_q     <= primed_q | ~match;
      ringing_q    <= (state_d == RINGING);
      snoozed_q    <= (state_d == SNOOZE);

      // Counters restart on every state entry so each timeout is exact.
      if ((state_d != state_q) || (state_d == IDLE)) begin
        tick_q <= '0;
        sec_q  <= '0;
      end else if (tick_wrap) begin
        tick_q <= '0;
        sec_q  <= sec_q + 16'd1;
      end else begin
        tick_q <= tick_q + 1'b1;
      end

      if ((state_d == RINGING) && (state_q == RINGING)) begin
        if (tone_wrap) begin
          tone_q   <= '0;
          buzzer_q <= ~buzzer_q;
        end else begin
          tone_q <= tone_q + 1'b1;
        end
      end else begin
        tone_q   <= '0;
        buzzer_q <= 1'b0;
      end
    end
  end

  assign buzzer  = buzzer_q;
  assign ringing = ringing_q;
  assign snoozed = snoozed_q;

endmodule

// File: tb/tb_alarm_trigger.sv
// Directed bench for alarm_trigger: a step table for the main ring cycle
// plus hand sequences for buttons, enable drop and reset corners.
module tb_alarm_trigger;

  logic       clk = 1'b0;
  logic       rst;
  logic       alarm_en;
  logic [7:0] time_hour, time_minute, time_second;
  logic [7:0] alarm_hour, alarm_minute, alarm_second;
  logic       stop_n, snooze_n;
  logic       buzzer, ringing, snoozed;

  int checks = 0;
  int errors = 0;

  alarm_trigger #(
    .TICK_DIV   (10),
    .TONE_DIV   (2),
    .RING_SEC   (3),
    .SNOOZE_SEC (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .alarm_en     (alarm_en),
    .time_hour    (time_hour),
    .time_minute  (time_minute),
    .time_second  (time_second),
    .alarm_hour   (alarm_hour),
    .alarm_minute (alarm_minute),
    .alarm_second (alarm_second),
    .stop_n       (stop_n),
    .snooze_n     (snooze_n),
    .buzzer       (buzzer),
    .ringing      (ringing),
    .snoozed      (snoozed)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [7:0] th, tm, ts, ah, am, as;
    int         n;
    logic       r, s, b;
  } vec_t;

  vec_t vt[20];

  function automatic vec_t mk(input logic en, input logic [7:0] th, tm, ts,
                              input logic [7:0] ah, am, as, input int n,
                              input logic r, s, b);
    vec_t v;
    v.en = en; v.th = th; v.tm = tm; v.ts = ts;
    v.ah = ah; v.am = am; v.as = as;
    v.n = n; v.r = r; v.s = s; v.b = b;
    return v;
  endfunction

  task automatic chk(input string nm, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", nm, got, exp);
    end
  endtask

  task automatic chk3(input string nm, input logic r, s, b);
    chk({nm, "_ringing"}, ringing, r);
    chk({nm, "_snoozed"}, snoozed, s);
    chk({nm, "_buzzer"},  buzzer,  b);
  endtask

  // Advance n rising edges, then settle on the falling edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_t(input logic [7:0] h, m, s);
    time_hour = h; time_minute = m; time_second = s;
  endtask

  task automatic set_a(input logic [7:0] h, m, s);
    alarm_hour = h; alarm_minute = m; alarm_second = s;
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; alarm_en = 1'b1; stop_n = 1'b1; snooze_n = 1'b1;
    set_t(8'd0, 8'd0, 8'd0);
    set_a(8'd7, 8'd30, 8'd0);

    // Step table: apply fields, advance n edges, compare outputs.
    vt[0]  = mk(1, 6,  30, 0,  7, 30, 0,  3,  0, 0, 0);  // hour differs
    vt[1]  = mk(1, 7,  31, 0,  7, 30, 0,  3,  0, 0, 0);  // minute differs
    vt[2]  = mk(1, 7,  30, 1,  7, 30, 0,  3,  0, 0, 0);  // second differs
    vt[3]  = mk(0, 7,  30, 0,  7, 30, 0,  3,  0, 0, 0);  // disarmed match
    vt[4]  = mk(1, 7,  29, 59, 7, 30, 0,  3,  0, 0, 0);
    vt[5]  = mk(1, 7,  30, 0,  7, 30, 0,  1,  0, 0, 0);  // match registered
    vt[6]  = mk(1, 7,  30, 0,  7, 30, 0,  1,  1, 0, 0);  // ring entry E
    vt[7]  = mk(1, 7,  30, 0,  7, 30, 0,  1,  1, 0, 0);  // E+1
    vt[8]  = mk(1, 7,  30, 0,  7, 30, 0,  1,  1, 0, 1);  // E+2 first toggle
    vt[9]  = mk(1, 7,  30, 0,  7, 30, 0,  2,  1, 0, 0);  // E+4
    vt[10] = mk(1, 7,  30, 0,  7, 30, 0,  2,  1, 0, 1);  // E+6
    vt[11] = mk(1, 7,  30, 0,  7, 30, 0,  23, 1, 0, 0);  // E+29 last ring cycle
    vt[12] = mk(1, 7,  30, 0,  7, 30, 0,  1,  0, 0, 0);  // E+30 auto-stop
    vt[13] = mk(1, 7,  30, 0,  7, 30, 0,  50, 0, 0, 0);  // held match, no retrigger
    vt[14] = mk(1, 7,  30, 1,  7, 30, 0,  2,  0, 0, 0);
    vt[15] = mk(1, 7,  30, 0,  7, 30, 0,  2,  1, 0, 0);  // back to alarm time
    vt[16] = mk(0, 7,  30, 0,  7, 30, 0,  1,  0, 0, 0);  // disarm mid-ring
    vt[17] = mk(1, 7,  30, 0,  23, 59, 59, 3, 0, 0, 0);
    vt[18] = mk(1, 23, 59, 59, 23, 59, 59, 2, 1, 0, 0);  // new alarm time
    vt[19] = mk(1, 23, 59, 59, 0,  0,  0,  3, 1, 0, 1);  // alarm edit ignored

    step(2);
    chk3("reset", 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      alarm_en = vt[i].en;
      set_t(vt[i].th, vt[i].tm, vt[i].ts);
      set_a(vt[i].ah, vt[i].am, vt[i].as);
      step(vt[i].n);
      chk3($sformatf("row%0d", i), vt[i].r, vt[i].s, vt[i].b);
    end

    // Snooze while ringing, snooze timeout back to ringing, then stop.
    snooze_n = 1'b0;
    step(3);
    chk3("snz_wait", 1'b1, 1'b0, 1'b1);
    step(1);
    chk3("snz_enter", 1'b0, 1'b1, 1'b0);
    snooze_n = 1'b1;
    step(19);
    chk3("snz_last", 1'b0, 1'b1, 1'b0);
    step(1);
    chk3("snz_rering", 1'b1, 1'b0, 1'b0);
    step(2);
    chk("rering_tone", buzzer, 1'b1);
    stop_n = 1'b0;
    step(3);
    chk("stop_wait", ringing, 1'b1);
    step(1);
    chk3("stop_ring", 1'b0, 1'b0, 1'b0);
    stop_n = 1'b1;

    // Stop and snooze together count as stop.
    set_a(8'd7, 8'd30, 8'd0);
    set_t(8'd7, 8'd30, 8'd0);
    step(2);
    chk("both_ring", ringing, 1'b1);
    stop_n = 1'b0; snooze_n = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step(1);
      chk($sformatf("both_snz%0d", k), snoozed, 1'b0);
    end
    chk("both_idle", ringing, 1'b0);
    stop_n = 1'b1; snooze_n = 1'b1;
    step(3);

    // Stop press during snooze.
    set_t(8'd7, 8'd30, 8'd1); step(2);
    set_t(8'd7, 8'd30, 8'd0); step(2);
    chk("c_ring", ringing, 1'b1);
    snooze_n = 1'b0; step(4);
    chk("c_snz", snoozed, 1'b1);
    snooze_n = 1'b1;
    stop_n = 1'b0; step(4);
    chk3("c_stop_snz", 1'b0, 1'b0, 1'b0);
    stop_n = 1'b1; step(3);

    // Disarm mid-snooze, rearm retriggers, reset mid-ring.
    set_t(8'd7, 8'd30, 8'd1); step(2);
    set_t(8'd7, 8'd30, 8'd0); step(2);
    snooze_n = 1'b0; step(4);
    snooze_n = 1'b1;
    step(5);
    chk("d_snz_mid", snoozed, 1'b1);
    alarm_en = 1'b0; step(1);
    chk3("d_disarm", 1'b0, 1'b0, 1'b0);
    alarm_en = 1'b1; step(2);
    chk3("d_rearm", 1'b1, 1'b0, 1'b0);
    step(2);
    chk("d_tone", buzzer, 1'b1);
    rst = 1'b1;
    #1;
    chk3("d_async_rst", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    step(20);
    chk3("d_no_trig_after_rst", 1'b0, 1'b0, 1'b0);
    set_t(8'd7, 8'd30, 8'd1); step(2);
    set_t(8'd7, 8'd30, 8'd0); step(2);
    chk("d_trig_after_drop", ringing, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
